poly_reduce_seq: RTL and testbench
==================================

# poly_reduce_seq

Parametrised, handshaked polynomial reduction stage for the ECC datapath. It takes the 2M-1 coefficient product produced by the multiplier's partial-product stage and reduces it modulo the trinomial x^M + x^K + 1, giving M coefficients. Reduction runs iteratively, one high coefficient folded per cycle. Coefficient addition is selectable per operation: integer add mod 2^W, or GF(2) XOR.

## Interface
- W, 8, coefficient width in bits
- M, 5, field degree; the output has M coefficients and the input has 2M-1
- K, 2, middle tap of the reduction trinomial; x^M ≡ x^K + 1; legal range 1 ≤ K ≤ M-1
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  product on s_in is valid
- in_ready  output  1  block is idle and can accept a product
- s_in  input  (2M-1)*W  product coefficients; coefficient i sits at bits [i*W +: W]
- xor_mode  input  1  0 = integer add mod 2^W; 1 = bitwise XOR; sampled at acceptance
- out_valid  output  1  c_out holds a reduced result
- out_ready  input  1  consumer accepts c_out
- c_out  output  M*W  reduced coefficients; coefficient i sits at bits [i*W +: W]
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, FOLD, DONE.
- Datapath:
  - acc: array of 2M-1 registers, each W bits.
  - j: index register, wide enough to hold 2M-2.
  - mode_r: 1-bit register holding the sampled mode.
- IDLE:
  - in_ready = 1.
  - When in_valid = 1, the block loads acc ← s_in, mode_r ← xor_mode, j ← 2M-2, and moves to FOLD.
- FOLD, each cycle:
  - acc[j-M] ← acc[j-M] ⊕ acc[j].
  - acc[j-M+K] ← acc[j-M+K] ⊕ acc[j].
  - acc[j] ← 0.
  - j ← j-1.
  - ⊕ means + truncated to W bits when mode_r = 0, and ^ when mode_r = 1.
  - Both targets are read from acc before the update. The two targets are always distinct because K ≥ 1.
  - Target j-M+K may be ≥ M. It is always < j, so a later fold picks it up.
  - When the fold with j = M completes, the next state is DONE.
- DONE:
  - out_valid = 1.
  - c_out = acc[M-1:0].
  - When out_ready = 1, the next state is IDLE.
- c_out is driven directly from acc[M-1:0]. It holds its value after DONE until the next acceptance.
- Integer-mode overflow wraps mod 2^W silently. There is no carry or overflow flag.
- Illegal parameters (M < 2, or K outside 1..M-1) must be caught by a generate-time check that halts elaboration (`$fatal`/`$error` in an initial block).

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, c_out = 0 (all acc = 0), j = 0, mode_r = 0.
- Acceptance edge: the rising edge where state = IDLE and in_valid = 1. in_ready is a combinational decode of state.
- FOLD lasts exactly M-1 cycles.
- Latency: out_valid rises in the cycle that follows the M-1th fold edge after acceptance; for M = 5 that is 4 cycles.
- Minimum initiation interval is M+1 cycles: accept, M-1 folds, then one DONE cycle with out_ready = 1.
- There is no overlap between operations. in_ready = 0 from the acceptance edge until the DONE handshake edge, and s_in and in_valid are ignored during that time.
- out_ready = 0 in DONE stalls indefinitely. c_out and out_valid stay stable while stalled.
- In-flight changes to xor_mode have no effect.
- reset = 1 in any state returns the block to the reset values on the next edge. The partial result is discarded and no out_valid pulse is produced.
- If reset and in_valid are both high, reset wins and nothing is accepted.

## Test plan
- Add mode, W=8, M=5, K=2, s_in coefficients 1..9 (s0 = 1), out_ready = 1:
  - Required: c_out = {c0 = 16, c1 = 9, c2 = 26, c3 = 20, c4 = 13}.
  - out_valid exactly 4 cycles after acceptance, for 1 cycle.
  - in_ready returns on the following cycle.
- XOR mode, same input: c_out = {14, 5, 4, 10, 13}.
- Wrap-around: all coefficients 0xFF, add mode → c_out = {0xFD, 0xFE, 0xFC, 0xFD, 0xFE}.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE; c_out and out_valid stay stable and in_ready stays 0.
  - A new in_valid during that window is not accepted.
  - After the handshake, the next product is accepted.
- Reset mid-FOLD (after 2 folds):
  - All outputs return to their reset values on the next edge.
  - No out_valid appears.
  - A fresh product then completes correctly.
- Mode latch: present xor_mode = 1 at acceptance, then drive it to 0 during FOLD; the result equals the pure-XOR reference.

Source files
------------

// File: rtl/poly_reduce_seq.sv
// Iterative reduction of a (2M-1)-coefficient product modulo x^M + x^K + 1.
// One high coefficient is folded per cycle, using integer add or GF(2) XOR.
module poly_reduce_seq #(
  parameter int W = 8,
  parameter int M = 5,
  parameter int K = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [(2*M-1)*W-1:0] s_in,
  input  logic                 xor_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M*W-1:0]       c_out,
  output logic                 busy
);

  localparam int N  = 2*M-1;
  localparam int JW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [W-1:0]  acc_r     [N];
  logic [W-1:0]  acc_nxt_s [N];
  logic [JW-1:0] j_r;
  logic          mode_r;
  logic          out_valid_r;
  logic [W-1:0]  top_s;
  int            j_int_s;

  if (M < 2 || K < 1 || K > M-1) begin : g_param_check
    initial $fatal(1, "poly_reduce_seq: illegal parameters M=%0d K=%0d", M, K);
  end

  function automatic logic [W-1:0] coef_add(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         xm);
    logic [W-1:0] r;
    if (xm) begin
      r = a ^ b;
    end else begin
      r = a + b;
    end
    return r;
  endfunction

  // Fold step: both targets read the pre-update acc, the folded slot is cleared.
  always_comb begin
    j_int_s = int'(j_r);
    top_s   = '0;
    for (int i = 0; i < N; i++) begin
      top_s = (i == j_int_s) ? acc_r[i] : top_s;
    end
    for (int i = 0; i < N; i++) begin
      if (i == j_int_s - M) begin
        acc_nxt_s[i] = coef_add(acc_r[i], top_s, mode_r);
      end else if (i == j_int_s - M + K) begin
        acc_nxt_s[i] = coef_add(acc_r[i], top_s, mode_r);
      end else if (i == j_int_s) begin
        acc_nxt_s[i] = '0;
      end else begin
        acc_nxt_s[i] = acc_r[i];
      end
    end
  end

  // Control FSM together with the accumulator, index and mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      j_r         <= '0;
      mode_r      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              acc_r[i] <= s_in[i*W +: W];
            end
            mode_r  <= xor_mode;
            j_r     <= JW'(N-1);
            state_r <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          for (int i = 0; i < N; i++) begin
            acc_r[i] <= acc_nxt_s[i];
          end
          j_r <= j_r - JW'(1);
          // The fold at j = M is the last one; results now sit in acc[M-1:0].
          if (j_r == JW'(M)) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Result is taken straight from the low accumulator slots.
  always_comb begin
    c_out = '0;
    for (int i = 0; i < M; i++) begin
      c_out[i*W +: W] = acc_r[i];
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_poly_reduce_seq.sv
// Self-checking bench for poly_reduce_seq: a transaction model built from
// x^i mod (x^M + x^K + 1) multiplicities, plus hand-computed vectors.
module tb_poly_reduce_seq;

  localparam int W  = 8;
  localparam int M  = 5;
  localparam int K  = 2;
  localparam int N  = 2*M-1;
  localparam int SW = N*W;
  localparam int MW = M*W;

  localparam logic [MW-1:0] EXP_ADD  = {8'd13, 8'd20, 8'd26, 8'd9, 8'd16};
  localparam logic [MW-1:0] EXP_XOR  = {8'd13, 8'd10, 8'd4, 8'd5, 8'd14};
  localparam logic [MW-1:0] EXP_WRAP = {8'hFE, 8'hFD, 8'hFC, 8'hFE, 8'hFD};

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] s_in;
  logic          xor_mode;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] c_out;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  poly_reduce_seq #(.W(W), .M(M), .K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .xor_mode  (xor_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: reduce each x^i over the integers, then combine the input
  // coefficients by those multiplicities (sum mod 2^W, or parity for XOR).
  function automatic logic [MW-1:0] ref_reduce(input logic [SW-1:0] s, input logic xm);
    int           r [N][M];
    int           top;
    int           sum;
    logic [W-1:0] xv;
    logic [MW-1:0] o;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++)
        r[i][k] = (i == k) ? 1 : 0;
    for (int i = M; i < N; i++) begin
      top = r[i-1][M-1];
      for (int k = 0; k < M; k++)
        r[i][k] = (k > 0) ? r[i-1][k-1] : 0;
      r[i][0] += top;
      r[i][K] += top;
    end
    o = '0;
    for (int k = 0; k < M; k++) begin
      sum = 0;
      xv  = '0;
      for (int i = 0; i < N; i++) begin
        sum += int'(s[i*W +: W]) * r[i][k];
        if (r[i][k] % 2 == 1) xv ^= s[i*W +: W];
      end
      o[k*W +: W] = xm ? xv : sum[W-1:0];
    end
    return o;
  endfunction

  function automatic logic [SW-1:0] ramp(input int base, input int step);
    logic [SW-1:0] s;
    int            v;
    s = '0;
    for (int i = 0; i < N; i++) begin
      v = base + i*step;
      s[i*W +: W] = v[W-1:0];
    end
    return s;
  endfunction

  // Transaction-level model of the handshake and the expected held result.
  typedef enum int {P_IDLE, P_FOLD, P_DONE} phase_t;
  phase_t        m_phase = P_IDLE;
  int            m_left  = 0;
  logic [MW-1:0] m_res   = '0;
  logic [MW-1:0] m_out   = '0;
  bit            m_armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= P_IDLE;
      m_out   <= '0;
      m_armed <= 1'b1;
    end else begin
      case (m_phase)
        P_IDLE: if (in_valid) begin
          m_res   <= ref_reduce(s_in, xor_mode);
          m_left  <= M-1;
          m_phase <= P_FOLD;
        end
        P_FOLD: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= P_DONE;
            m_out   <= m_res;
          end
        end
        default: if (out_ready) m_phase <= P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("mdl_in_ready", 128'(in_ready), 128'(m_phase == P_IDLE));
      check("mdl_busy", 128'(busy), 128'(m_phase != P_IDLE));
      check("mdl_out_valid", 128'(out_valid), 128'(m_phase == P_DONE));
      if (m_phase != P_FOLD) check("mdl_c_out", 128'(c_out), 128'(m_out));
    end
  end

  task automatic do_op(input logic [SW-1:0] s, input logic xm, input int stall,
                       output logic [MW-1:0] res, output int lat);
    logic [95:0] junk;
    in_valid  = 1'b1;
    s_in      = s;
    xor_mode  = xm;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    xor_mode = ~xm;
    junk     = {$urandom(), $urandom(), $urandom()};
    s_in     = junk[SW-1:0];
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    if (out_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_timeout: out_valid not seen within %0d cycles", lat);
    end
    res = c_out;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      s_in     = ramp(40 + i, 3);
      @(posedge clk); #1;
      check("stall_valid", 128'(out_valid), 128'(1'b1));
      check("stall_hold", 128'(c_out), 128'(res));
      check("stall_in_ready", 128'(in_ready), 128'(1'b0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_in_ready", 128'(in_ready), 128'(1'b1));
    check("post_out_valid", 128'(out_valid), 128'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MW-1:0] res;
    int            lat;
    bit            seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    s_in      = '0;
    xor_mode  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_c_out", 128'(c_out), 128'(0));
    reset = 1'b0;

    check("model_add", 128'(ref_reduce(ramp(1, 1), 1'b0)), 128'(EXP_ADD));
    check("model_xor", 128'(ref_reduce(ramp(1, 1), 1'b1)), 128'(EXP_XOR));
    check("model_wrap", 128'(ref_reduce({SW{1'b1}}, 1'b0)), 128'(EXP_WRAP));

    do_op(ramp(1, 1), 1'b0, 0, res, lat);
    check("add_result", 128'(res), 128'(EXP_ADD));
    check("add_latency", 128'(lat), 128'(4));

    do_op(ramp(1, 1), 1'b1, 0, res, lat);
    check("xor_latched_result", 128'(res), 128'(EXP_XOR));
    check("xor_latency", 128'(lat), 128'(4));

    do_op({SW{1'b1}}, 1'b0, 0, res, lat);
    check("wrap_result", 128'(res), 128'(EXP_WRAP));

    do_op(ramp(7, 29), 1'b0, 10, res, lat);
    check("bp_result", 128'(res), 128'(ref_reduce(ramp(7, 29), 1'b0)));
    do_op(ramp(1, 1), 1'b0, 0, res, lat);
    check("bp_next_result", 128'(res), 128'(EXP_ADD));
    check("bp_next_latency", 128'(lat), 128'(4));

    in_valid = 1'b1;
    s_in     = ramp(1, 1);
    xor_mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 128'(in_ready), 128'(1'b1));
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_c_out", 128'(c_out), 128'(0));
    reset    = 1'b0;
    in_valid = 1'b0;
    seen     = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_valid", 128'(seen), 128'(1'b0));
    do_op(ramp(1, 1), 1'b1, 0, res, lat);
    check("after_rst_result", 128'(res), 128'(EXP_XOR));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
